ldm_stm_sequencer: RTL

Multi-register transfer sequencer for block load/store (LDM/STM) instructions. It takes a 16-bit register list, base address and addressing mode, then walks the set bits lowest-first. For each set bit it issues one word memory transfer and drives the register-file port: a read for stores, a write for loads. It sits directly upstream of the register file and the memory interface, and finishes with the optional base-register writeback.

---
 rtl/ldm_stm_sequencer_pkg.sv | 24 ++
 rtl/ldm_stm_sequencer_lowest_set_bit.sv | 34 +++
 rtl/ldm_stm_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM multi-register transfer sequencer.
package ldm_stm_sequencer_pkg;

    // Sequencer control states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bytes per transferred word; addresses step by this amount per beat
    localparam int WORD_BYTES = 4;

    // Addressing mode encoded as {up, pre}
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,   // decrement after
        MODE_DB = 2'b01,   // decrement before
        MODE_IA = 2'b10,   // increment after
        MODE_IB = 2'b11    // increment before
    } addr_mode_t;

endpackage

// File: rtl/ldm_stm_sequencer_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a vector, plus a valid flag.
module lowest_set_bit #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Bit mask of all positions whose index has bit b set
    function automatic logic [WIDTH-1:0] index_mask(input int b);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = ((i >> b) & 1) != 0;
        end
        return m;
    endfunction

    // Isolate the lowest set bit as a one-hot vector (two's complement trick)
    logic [WIDTH-1:0] onehot;
    assign onehot = vec & (~vec + WIDTH'(1));
    assign valid  = |vec;

    // Each index bit is the OR of the one-hot positions carrying that bit
    generate
        for (genvar gi = 0; gi < IDX_W; gi++) begin : g_idx
            localparam logic [WIDTH-1:0] MASK = index_mask(gi);
            assign idx[gi] = |(onehot & MASK);
        end
    endgenerate

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list lowest-first, issuing one word
// memory transfer per set bit, then optionally writes back the base register.
module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LIST_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LIST_W-1:0] reg_list,
    input  logic [DATA_W-1:0] base_addr,
    input  logic [3:0]        base_reg,
    input  logic              load,
    input  logic              up,
    input  logic              pre,
    input  logic              writeback,
    output logic              busy,
    output logic              done,
    output logic [3:0]        xfer_reg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              reg_we,
    output logic [3:0]        reg_waddr,
    output logic [DATA_W-1:0] reg_wdata
);

    localparam int CNT_W = $clog2(LIST_W) + 1;

    // Number of registers named in a list
    function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < LIST_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    state_t            state_reg;
    logic [LIST_W-1:0] list_reg;
    logic [DATA_W-1:0] base_addr_reg;
    logic [3:0]        base_num_reg;
    logic              load_reg;
    addr_mode_t        mode_reg;
    logic              wb_en_reg;
    logic [DATA_W-1:0] addr_reg;
    logic [DATA_W-1:0] final_base_reg;

    logic [3:0]        lsb_idx;
    logic              lsb_valid;
    logic [LIST_W-1:0] list_rest;
    logic              last_beat;
    logic [DATA_W-1:0] span;
    logic [DATA_W-1:0] start_addr_next;
    logic [DATA_W-1:0] final_base_next;
    logic              beat_done;

    lowest_set_bit #(
        .WIDTH (LIST_W),
        .IDX_W (4)
    ) u_lsb (
        .vec   (list_reg),
        .idx   (lsb_idx),
        .valid (lsb_valid)
    );

    // Remaining list once the current beat retires, and whether it was the last
    assign list_rest = list_reg & (list_reg - LIST_W'(1));
    assign last_beat = (list_rest == '0);
    assign beat_done = (state_reg == ST_XFER) && lsb_valid && mem_ready;

    // Start and final base addresses; the lowest register always sits lowest
    always_comb begin
        span            = DATA_W'(popcount(list_reg)) * DATA_W'(WORD_BYTES);
        start_addr_next = base_addr_reg;
        case (mode_reg)
            MODE_IA: start_addr_next = base_addr_reg;
            MODE_IB: start_addr_next = base_addr_reg + DATA_W'(WORD_BYTES);
            MODE_DA: start_addr_next = base_addr_reg - span + DATA_W'(WORD_BYTES);
            MODE_DB: start_addr_next = base_addr_reg - span;
            default: start_addr_next = base_addr_reg;
        endcase
        final_base_next = mode_reg[1] ? (base_addr_reg + span) : (base_addr_reg - span);
    end

    // Sequencer FSM and captured operands
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            list_reg       <= '0;
            base_addr_reg  <= '0;
            base_num_reg   <= '0;
            load_reg       <= 1'b0;
            mode_reg       <= MODE_DA;
            wb_en_reg      <= 1'b0;
            addr_reg       <= '0;
            final_base_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        list_reg      <= reg_list;
                        base_addr_reg <= base_addr;
                        base_num_reg  <= base_reg;
                        load_reg      <= load;
                        mode_reg      <= addr_mode_t'({up, pre});
                        // A load that also fetches the base register keeps the loaded value
                        wb_en_reg     <= writeback && !(load && reg_list[base_reg]);
                        state_reg     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    addr_reg       <= start_addr_next;
                    final_base_reg <= final_base_next;
                    // An empty list still passes through one request-free XFER
                    // cycle, so done lands at start+3 like a single-beat transfer
                    state_reg      <= ST_XFER;
                end
                ST_XFER: begin
                    if (!lsb_valid) begin
                        state_reg <= ST_DONE;
                    end else if (mem_ready) begin
                        list_reg <= list_rest;
                        addr_reg <= addr_reg + DATA_W'(WORD_BYTES);
                        if (last_beat) begin
                            state_reg <= wb_en_reg ? ST_WB : ST_DONE;
                        end
                    end
                end
                ST_WB:   state_reg <= ST_DONE;
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Memory and register-file port drive, decoded from the registered state
    always_comb begin
        busy      = (state_reg == ST_SETUP) || (state_reg == ST_XFER) || (state_reg == ST_WB);
        done      = (state_reg == ST_DONE);
        mem_req   = (state_reg == ST_XFER) && lsb_valid;
        mem_we    = mem_req && !load_reg;
        xfer_reg  = (state_reg == ST_XFER) ? lsb_idx : 4'd0;
        mem_addr  = addr_reg;
        reg_we    = 1'b0;
        reg_waddr = 4'd0;
        reg_wdata = '0;
        if (state_reg == ST_WB) begin
            reg_we    = 1'b1;
            reg_waddr = base_num_reg;
            reg_wdata = final_base_reg;
        end else if (beat_done && load_reg) begin
            reg_we    = 1'b1;
            reg_waddr = lsb_idx;
            reg_wdata = mem_rdata;
        end
    end

endmodule
